pulse_level_driver: RTL and testbench
=====================================

// Module: pulse_level_driver
// PURPOSE
//   Converts single-cycle request pulses into held output levels: the transmit side of the
//   synchronized-button interface (ButtonSynchronizer turns a level into a pulse; this block
//   turns each pulse back into a timed level). Drives vending-machine dispense/LED/solenoid
//   lines from FSM one-shots.
//   Queues requests in a saturating counter and emits one HOLD/GAP waveform per request.
// PARAMETERS
//   HOLD_CYCLES  4  cycles level_out is high per request (>=1)
//   GAP_CYCLES   2  min low cycles between consecutive levels (0 allowed)
//   PEND_W       2  pending counter width; max queued = 2**PEND_W-1
//   TMR_W        8  timer width; must hold max(HOLD_CYCLES,GAP_CYCLES)-1
// PORTS
//   Clk        in   1       clock, all state on rising edge
//   Rst        in   1       reset, asynchronous, active-high
//   pulse_in   in   1       request; each high cycle = one request
//   level_out  out  1       held output level, registered
//   busy       out  1       1 when state!=IDLE or pending!=0
//   pending    out  PEND_W  queued requests not yet started
//   overflow   out  1       sticky request-dropped flag (see CONFIGURATION)
// BEHAVIOUR
//   Reset: state=IDLE, timer=0, pending=0, level_out=0, busy=0, overflow=0; asserting Rst
//     mid-operation clears all state immediately (level_out falls without waiting for edge).
//   States: IDLE, HOLD, GAP. level_out=1 only in HOLD (registered from next-state).
//   pending update per edge: +1 if pulse_in, -1 if a level starts this edge; both -> unchanged.
//     Saturates at 2**PEND_W-1: pulse_in at max with no start -> request dropped.
//   IDLE: if pending!=0 -> HOLD, timer<=HOLD_CYCLES-1, start (decrement). A pulse_in is
//     never started in the edge it is sampled: latency pulse_in edge k -> level high after k+1.
//   HOLD: timer!=0 -> timer-1. timer==0 -> if GAP_CYCLES>0: GAP, timer<=GAP_CYCLES-1;
//     else if pending!=0: HOLD again (start); else IDLE.
//   GAP: timer!=0 -> timer-1. timer==0 -> pending!=0 ? HOLD (start) : IDLE.
//   Result: each level exactly HOLD_CYCLES high; queued levels repeat with period
//     HOLD_CYCLES+GAP_CYCLES; with GAP_CYCLES=0 level_out stays high continuously across them.
//   pulse_in held high N cycles = N requests (subject to saturation).
//   busy is combinational from registered state and pending.
// CONFIGURATION
//   OVF_FLAG_EN defined: overflow set the edge a request is dropped; sticky until Rst.
//   OVF_FLAG_EN undefined: no overflow logic; overflow tied 0; drops are silent.
// TESTING  (HOLD_CYCLES=4, GAP_CYCLES=2, PEND_W=2, OVF_FLAG_EN defined unless stated)
//   Reset: Rst=1 for 1 cycle, pulse_in=0 -> level_out=0, busy=0, pending=0, overflow=0.
//   Single: pulse_in high at edge 5 only -> pending=1 after 5; level_out=1 after edges 6..9,
//     0 after 10; busy=1 after 5 through 11, 0 after edge 12.
//   Back-to-back: pulses at edges 5 and 7 -> levels high after 6..9 and after 12..15
//     (period 6); pending=1 after 7, 0 after 12.
//   Saturate: pulse_in high at edges 5-9 -> pending 1,1,2,3,3; edge 9 dropped, overflow=1
//     after 9 and stays 1; exactly 4 levels out. With OVF_FLAG_EN undefined: same levels,
//     overflow=0.
//   Simultaneous: pending=1 in GAP, pulse_in coincident with GAP->HOLD edge -> pending
//     stays 1, level rises.
//   Reset mid-HOLD: Rst=1 during 2nd HOLD cycle with pending=2 -> level_out=0 before next
//     edge, pending=0, overflow=0; after release no level until new pulse_in.

Source files
------------

// File: rtl/pulse_level_driver.sv
// ----------------------------------------------------------------------------
// pulse_level_driver
//
// Turns single-cycle request pulses back into timed output levels. Every
// cycle pulse_in is high counts as one request; requests wait in a saturating
// pending counter and each one produces exactly HOLD_CYCLES of level_out high,
// followed by at least GAP_CYCLES low before the next queued level starts.
//
// Parameters:
//   HOLD_CYCLES  cycles level_out is high per request (>= 1)
//   GAP_CYCLES   minimum low cycles between consecutive levels (0 allowed)
//   PEND_W       pending counter width; at most 2**PEND_W-1 requests queue
//   TMR_W        timer width; must hold max(HOLD_CYCLES, GAP_CYCLES)-1
//
// Ports:
//   Clk        in   1       clock, all state updates on the rising edge
//   Rst        in   1       asynchronous, active-high reset
//   pulse_in   in   1       request strobe; each high cycle is one request
//   level_out  out  1       held output level, registered
//   busy       out  1       high while a level/gap is running or requests wait
//   pending    out  PEND_W  queued requests that have not started yet
//   overflow   out  1       sticky flag: a request was dropped at saturation
//
// Build option:
//   OVF_FLAG_EN  when defined, overflow is set on the edge a request is
//                dropped and holds until Rst. When undefined, overflow is
//                tied low and drops are silent.
// ----------------------------------------------------------------------------
module pulse_level_driver #(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 2,
    parameter int PEND_W      = 2,
    parameter int TMR_W       = 8
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              pulse_in,
    output logic              level_out,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [TMR_W-1:0]  HOLD_LOAD = TMR_W'(HOLD_CYCLES - 1);
    // With no gap this load value is never used; clamp it so it stays legal.
    localparam logic [TMR_W-1:0]  GAP_LOAD  = TMR_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [PEND_W-1:0] PEND_MAX  = '1;
    localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);

    state_t            state;
    state_t            state_nxt;
    logic [TMR_W-1:0]  timer;
    logic [TMR_W-1:0]  timer_nxt;
    logic [PEND_W-1:0] pending_nxt;
    logic              start;   // a queued request begins its level this edge
    logic              drop;    // a request arrives with nowhere to go

    // ------------------------------------------------------------------------
    // Next-state logic. A level can only start from a request already counted
    // in pending, so a pulse sampled on this edge never starts on this edge.
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of a combinational block gets a default first;
        // any path that skips an assignment would otherwise infer a latch.
        state_nxt = state;
        timer_nxt = timer;
        start     = 1'b0;

        unique case (state)
            IDLE: begin
                if (pending != '0) begin
                    state_nxt = HOLD;
                    timer_nxt = HOLD_LOAD;
                    start     = 1'b1;
                end
            end

            HOLD: begin
                if (timer != '0) begin
                    timer_nxt = timer - 1'b1;
                end else if (GAP_CYCLES > 0) begin
                    state_nxt = GAP;
                    timer_nxt = GAP_LOAD;
                end else if (pending != '0) begin
                    // No gap: chain straight into the next level, output stays high.
                    state_nxt = HOLD;
                    timer_nxt = HOLD_LOAD;
                    start     = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end

            GAP: begin
                if (timer != '0) begin
                    timer_nxt = timer - 1'b1;
                end else if (pending != '0) begin
                    state_nxt = HOLD;
                    timer_nxt = HOLD_LOAD;
                    start     = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
                timer_nxt = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Pending counter: +1 per request, -1 per start, unchanged when both
    // happen together. A request that would push past PEND_MAX is dropped;
    // a simultaneous start frees a slot, so that case is not a drop.
    // ------------------------------------------------------------------------
    always_comb begin
        drop        = pulse_in && !start && (pending == PEND_MAX);
        pending_nxt = pending;
        unique case ({pulse_in, start})
            2'b10:   pending_nxt = drop ? pending : pending + PEND_ONE;
            2'b01:   pending_nxt = pending - PEND_ONE;
            default: pending_nxt = pending;
        endcase
    end

    // ------------------------------------------------------------------------
    // State registers. level_out is registered from the next state so it is
    // glitch-free and aligned with the HOLD state itself.
    // ------------------------------------------------------------------------
    // NOTE: the reset is asynchronous so level_out drops the moment Rst rises,
    // without waiting for a clock edge.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state     <= IDLE;
            timer     <= '0;
            pending   <= '0;
            level_out <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            state     <= state_nxt;
            timer     <= timer_nxt;
            pending   <= pending_nxt;
            level_out <= (state_nxt == HOLD);
        end
    end

    assign busy = (state != IDLE) || (pending != '0);

`ifdef OVF_FLAG_EN
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end
    end
`else
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_pulse_level_driver.sv
// ----------------------------------------------------------------------------
// tb_pulse_level_driver
//
// Scoreboard bench for pulse_level_driver (HOLD=4, GAP=2, PEND_W=2).
// The driver applies one stimulus per cycle and pushes the expected outputs
// for the coming edge; the monitor pops and compares one entry after every
// rising edge. The reference model works on request timelines: each accepted
// request gets a start edge max(arrival+1, previous start + HOLD + GAP), and
// all outputs follow from those start edges.
// ----------------------------------------------------------------------------
module tb_pulse_level_driver;

    localparam int H    = 4;
    localparam int G    = 2;
    localparam int PW   = 2;
    localparam int PMAX = (1 << PW) - 1;

    logic          Clk;
    logic          Rst;
    logic          pulse_in;
    logic          level_out;
    logic          busy;
    logic [PW-1:0] pending;
    logic          overflow;

    pulse_level_driver #(
        .HOLD_CYCLES (H),
        .GAP_CYCLES  (G),
        .PEND_W      (PW),
        .TMR_W       (8)
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .pulse_in  (pulse_in),
        .level_out (level_out),
        .busy      (busy),
        .pending   (pending),
        .overflow  (overflow)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        int edge_no;
        bit level;
        bit busy;
        int pending;
        bit ovf;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int starts[$];     // start edges of accepted requests not yet begun
    int last_start;    // start edge of the newest accepted request
    int cur_start;     // start edge of the level most recently begun
    bit m_ovf;
    int edge_no = 0;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic model_reset();
        starts.delete();
        last_start = -1000;
        cur_start  = -1000;
        m_ovf      = 1'b0;
    endtask

    // Advance the model across edge e with request p, return expected outputs.
    task automatic model_edge(input int e, input bit p, input bit r, output exp_t x);
        int  pend_before;
        bit  start_now;
        int  s;
        x.edge_no = e;
        if (r) begin
            model_reset();
        end else begin
            pend_before = starts.size();
            start_now   = (pend_before > 0) && (starts[0] == e);
            if (start_now) begin
                void'(starts.pop_front());
                cur_start = e;
            end
            if (p) begin
                if (pend_before == PMAX && !start_now) begin
                    m_ovf = 1'b1;
                end else begin
                    s = imax(e + 1, last_start + H + G);
                    starts.push_back(s);
                    last_start = s;
                end
            end
        end
        x.pending = starts.size();
        x.level   = (e >= cur_start) && (e <= cur_start + H - 1);
        x.busy    = (starts.size() != 0) || (e < cur_start + H + G);
`ifdef OVF_FLAG_EN
        x.ovf     = m_ovf;
`else
        x.ovf     = 1'b0;
`endif
    endtask

    // One cycle of stimulus: drive at the falling edge, predict the next edge.
    task automatic step(input bit p, input bit r);
        exp_t x;
        @(negedge Clk);
        pulse_in = p;
        Rst      = r;
        edge_no++;
        model_edge(edge_no, p, r, x);
        sb_q.push_back(x);
        if (r) begin
            // Asynchronous clear must be visible before the next edge.
            #1;
            check("async_rst_level",   int'(level_out), 0);
            check("async_rst_pending", int'(pending),   0);
            check("async_rst_busy",    int'(busy),      0);
            check("async_rst_ovf",     int'(overflow),  0);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0);
    endtask

    // Monitor: one expected entry per rising edge.
    initial begin
        forever begin
            @(posedge Clk);
            #1;
            if (sb_q.size() != 0) begin
                mon_e = sb_q.pop_front();
                check($sformatf("level@%0d",   mon_e.edge_no), int'(level_out), int'(mon_e.level));
                check($sformatf("busy@%0d",    mon_e.edge_no), int'(busy),      int'(mon_e.busy));
                check($sformatf("pending@%0d", mon_e.edge_no), int'(pending),   mon_e.pending);
                check($sformatf("ovf@%0d",     mon_e.edge_no), int'(overflow),  int'(mon_e.ovf));
            end
        end
    end

    // Watchdog so the run cannot hang.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int dens;
        pulse_in = 1'b0;
        Rst      = 1'b0;
        model_reset();

        // Reset
        step(1'b0, 1'b1);
        idle(3);

        // Single request
        step(1'b1, 1'b0);
        idle(10);

        // Back-to-back: pulses two edges apart
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        idle(16);

        // Saturate: five consecutive request cycles, last one dropped
        repeat (5) step(1'b1, 1'b0);
        idle(30);

        // Pulse coincident with the GAP->HOLD edge while one is pending
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        idle(5);
        step(1'b1, 1'b0);
        idle(20);

        // Reset during the second HOLD cycle with two requests pending
        repeat (3) step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        idle(12);

        // Randomized traffic with varying request density and rare resets
        for (int blk = 0; blk < 8; blk++) begin
            dens = $urandom_range(5, 90);
            for (int i = 0; i < 50; i++) begin
                step(($urandom_range(0, 99) < dens), ($urandom_range(0, 149) == 0));
            end
        end
        idle(30);

        @(posedge Clk);
        #2;
        check("scoreboard_drained", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
